interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_pkg.sv | 14 +
 rtl/interrupt_controller_if.sv | 23 ++
 rtl/interrupt_controller_irq_priority_encoder.sv | 15 +
 rtl/interrupt_controller.sv | 78 +++++++
 tb/tb_interrupt_controller.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg: shared state encodings, IO addresses and helpers
package interrupt_controller_pkg;
   typedef enum logic [1:0] {
      STATE_IDLE    = 2'd0,
      STATE_REQUEST = 2'd1,
      STATE_SERVICE = 2'd2
   } state_t;
   localparam int SREG_I_BIT = 7;
   localparam logic [15:0] IMSK_ADDR_DEFAULT = 16'h0039;
   localparam logic [15:0] IFR_ADDR_DEFAULT  = 16'h003A;
   function automatic int idx_width(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: core handshake and IO bus control between core and controller
interface interrupt_controller_if #(
   parameter int ADDR_WIDTH   = 16,
   parameter int I_ADDR_WIDTH = 10
);
   logic [ADDR_WIDTH-1:0]   bus_addr;
   logic                    io_cs;
   logic                    io_we;
   logic                    io_oe;
   logic                    global_ie;
   logic                    irq_ack;
   logic                    irq_done;
   logic                    irq;
   logic [I_ADDR_WIDTH-1:0] vector;
   modport master (
      output bus_addr, io_cs, io_we, io_oe, global_ie, irq_ack, irq_done,
      input  irq, vector
   );
   modport slave (
      input  bus_addr, io_cs, io_we, io_oe, global_ie, irq_ack, irq_done,
      output irq, vector
   );
endinterface

// File: rtl/interrupt_controller_irq_priority_encoder.sv
// irq_priority_encoder: combinational lowest-index-wins request encoder
module irq_priority_encoder import interrupt_controller_pkg::*; #(
   parameter int N = 8
) (
   input  logic [N-1:0]            i_req,
   output logic [idx_width(N)-1:0] o_idx,
   output logic                    o_valid
);
   localparam int IW = idx_width(N);
   always_comb begin
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--) o_idx = i_req[i] ? IW'(i) : o_idx;
   end
   assign o_valid = |i_req;
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-triggered, maskable, lowest-index-first interrupt controller
module interrupt_controller import interrupt_controller_pkg::*; #(
   parameter int                    IRQ_COUNT    = 8,
   parameter int                    I_ADDR_WIDTH = 10,
   parameter int                    DATA_WIDTH   = 8,
   parameter int                    ADDR_WIDTH   = 16,
   parameter int                    VECTOR_BASE  = 1,
   parameter logic [ADDR_WIDTH-1:0] MASK_ADDR    = ADDR_WIDTH'(IMSK_ADDR_DEFAULT),
   parameter logic [ADDR_WIDTH-1:0] FLAG_ADDR    = ADDR_WIDTH'(IFR_ADDR_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [IRQ_COUNT-1:0]  irq_lines,
   inout  wire  [DATA_WIDTH-1:0] bus_data,
   interrupt_controller_if.slave bus
);
   localparam int IW = idx_width(IRQ_COUNT);
   state_t                r_state, w_state_nxt;
   logic [IRQ_COUNT-1:0]  r_prev, r_pending, r_mask;
   logic [IRQ_COUNT-1:0]  w_edge, w_clr, w_cand, w_wdata;
   logic [IW-1:0]         r_sel, w_sel_nxt, w_idx;
   logic                  w_valid, w_mask_sel, w_flag_sel, w_mask_we, w_flag_we, w_oe;
   logic [DATA_WIDTH-1:0] w_rdata;
   assign w_mask_sel = bus.io_cs && bus.bus_addr == MASK_ADDR;
   assign w_flag_sel = bus.io_cs && bus.bus_addr == FLAG_ADDR;
   assign w_mask_we  = w_mask_sel && bus.io_we;
   assign w_flag_we  = w_flag_sel && bus.io_we;
   assign w_wdata    = IRQ_COUNT'(bus_data);
   assign w_edge     = irq_lines & ~r_prev;
   assign w_cand     = r_pending & r_mask;
   assign w_clr      = (w_flag_we ? w_wdata : '0)
                     | (r_state == STATE_REQUEST && bus.irq_ack ? IRQ_COUNT'(1) << r_sel : '0);
   assign w_oe       = bus.io_oe && (w_mask_sel || w_flag_sel);
   assign w_rdata    = DATA_WIDTH'(w_mask_sel ? r_mask : r_pending);
   assign bus_data   = w_oe ? w_rdata : 'z;
   assign bus.irq    = r_state == STATE_REQUEST;
   assign bus.vector = I_ADDR_WIDTH'(VECTOR_BASE) + I_ADDR_WIDTH'(r_sel);
   irq_priority_encoder #(.N(IRQ_COUNT)) u_prio (
      .i_req   (w_cand),
      .o_idx   (w_idx),
      .o_valid (w_valid)
   );
   // A new edge is OR-ed in after the clear so it always wins the same cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev    <= '0;
         r_pending <= '0;
         r_mask    <= '0;
      end else begin
         r_prev    <= irq_lines;
         r_pending <= (r_pending & ~w_clr) | w_edge;
         if (w_mask_we) r_mask <= w_wdata;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= STATE_IDLE;
         r_sel   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
      end
   end
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      case (r_state)
         STATE_IDLE: begin
            w_state_nxt = bus.global_ie && w_valid ? STATE_REQUEST : STATE_IDLE;
            w_sel_nxt   = bus.global_ie && w_valid ? w_idx : r_sel;
         end
         STATE_REQUEST: w_state_nxt = bus.irq_ack ? STATE_SERVICE
                                    : (bus.global_ie ? STATE_REQUEST : STATE_IDLE);
         STATE_SERVICE: w_state_nxt = bus.irq_done ? STATE_IDLE : STATE_SERVICE;
         default:       w_state_nxt = STATE_IDLE;
      endcase
   end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed and random checks against a behavioural model
module tb_interrupt_controller;
   localparam logic [15:0] MA = 16'h0039;
   localparam logic [15:0] FA = 16'h003A;
   logic       clk = 0;
   logic       reset = 0;
   logic [7:0] irq_lines = 0;
   wire  [7:0] bus_data;
   logic       tb_drv = 0;
   logic [7:0] tb_wdata = 0;
   logic [7:0] d;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] m_pend, m_mask, m_prev;
   int         m_phase, m_sel;
   interrupt_controller_if #(.ADDR_WIDTH(16), .I_ADDR_WIDTH(10)) bif ();
   interrupt_controller dut (
      .clk       (clk),
      .reset     (reset),
      .irq_lines (irq_lines),
      .bus_data  (bus_data),
      .bus       (bif)
   );
   assign bus_data = tb_drv ? tb_wdata : 'z;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction
   task automatic model_reset();
      m_pend = 0; m_mask = 0; m_prev = 0; m_phase = 0; m_sel = 0;
   endtask
   // phase 0 = idle, 1 = requesting, 2 = in service
   task automatic model_edge();
      logic [7:0] clr, cand;
      if (reset) begin
         model_reset();
         return;
      end
      clr  = 0;
      cand = m_pend & m_mask;
      if (bif.io_cs && bif.io_we && bif.bus_addr == FA) clr = tb_wdata;
      if (m_phase == 1 && bif.irq_ack) clr[m_sel] = 1'b1;
      if (m_phase == 0 && bif.global_ie && cand != 0) begin
         m_sel = lowest(cand);
         m_phase = 1;
      end else if (m_phase == 1 && bif.irq_ack) m_phase = 2;
      else if (m_phase == 1 && !bif.global_ie) m_phase = 0;
      else if (m_phase == 2 && bif.irq_done) m_phase = 0;
      m_pend = (m_pend & ~clr) | (irq_lines & ~m_prev);
      if (bif.io_cs && bif.io_we && bif.bus_addr == MA) m_mask = tb_wdata;
      m_prev = irq_lines;
   endtask
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("irq", 32'(bif.irq), 32'(m_phase == 1));
      chk("vector", 32'(bif.vector), 32'(1 + m_sel));
   endtask
   task automatic rd(input logic [15:0] a, output logic [7:0] v);
      bif.bus_addr = a; bif.io_cs = 1; bif.io_oe = 1;
      #1;
      v = bus_data;
      bif.io_cs = 0; bif.io_oe = 0; bif.bus_addr = 0;
   endtask
   task automatic wr(input logic [15:0] a, input logic [7:0] v);
      bif.bus_addr = a; bif.io_cs = 1; bif.io_we = 1; tb_drv = 1; tb_wdata = v;
      step();
      bif.io_cs = 0; bif.io_we = 0; tb_drv = 0; bif.bus_addr = 0;
   endtask
   task automatic pulse_ack();
      bif.irq_ack = 1; step(); bif.irq_ack = 0;
   endtask
   task automatic pulse_done();
      bif.irq_done = 1; step(); bif.irq_done = 0;
   endtask
   initial begin
      bif.bus_addr = 0; bif.io_cs = 0; bif.io_we = 0; bif.io_oe = 0;
      bif.global_ie = 0; bif.irq_ack = 0; bif.irq_done = 0;
      model_reset();
      #1 reset = 1;
      step(); step();
      chk("rst irq", 32'(bif.irq), 0);
      chk("rst vector", 32'(bif.vector), 1);
      rd(FA, d); chk("rst ifr", 32'(d), 0);
      rd(MA, d); chk("rst imsk", 32'(d), 0);
      reset = 0;
      bif.global_ie = 1;
      // single source, full latency and ack
      wr(MA, 8'hFF);
      rd(MA, d); chk("imsk write", 32'(d), 32'h00FF);
      irq_lines = 8'h08; step();
      rd(FA, d); chk("edge ifr", 32'(d), 32'h08);
      chk("edge irq not yet", 32'(bif.irq), 0);
      step();
      chk("req irq", 32'(bif.irq), 1);
      chk("req vector", 32'(bif.vector), 4);
      pulse_ack();
      rd(FA, d); chk("ack ifr", 32'(d), 0);
      chk("ack irq low", 32'(bif.irq), 0);
      irq_lines = 8'h09; step(); step();
      chk("service no nest", 32'(bif.irq), 0);
      rd(FA, d); chk("service pend", 32'(d), 32'h01);
      pulse_done(); step();
      chk("after done vector", 32'(bif.vector), 1);
      pulse_ack(); pulse_done();
      irq_lines = 0; step();
      // simultaneous edges, lowest index first
      irq_lines = 8'h24; step(); step();
      chk("prio vector", 32'(bif.vector), 3);
      pulse_ack(); pulse_done(); step();
      chk("second irq", 32'(bif.irq), 1);
      chk("second vector", 32'(bif.vector), 6);
      pulse_ack(); pulse_done();
      irq_lines = 0; step();
      // masked source held then released by IMSK
      wr(MA, 8'h00);
      irq_lines = 8'h02; step(); step(); step();
      chk("masked irq", 32'(bif.irq), 0);
      rd(FA, d); chk("masked ifr", 32'(d), 32'h02);
      wr(MA, 8'h02); step();
      chk("unmask irq", 32'(bif.irq), 1);
      chk("unmask vector", 32'(bif.vector), 2);
      pulse_ack(); pulse_done();
      irq_lines = 0; wr(MA, 8'hFF);
      // global_ie drop during request
      irq_lines = 8'h10; step(); step();
      chk("gie req vector", 32'(bif.vector), 5);
      bif.global_ie = 0; step();
      chk("gie drop irq", 32'(bif.irq), 0);
      rd(FA, d); chk("gie drop ifr", 32'(d), 32'h10);
      step();
      bif.global_ie = 1; step();
      chk("gie restore irq", 32'(bif.irq), 1);
      chk("gie restore vector", 32'(bif.vector), 5);
      pulse_ack(); pulse_done();
      irq_lines = 0; step();
      // edge beats same-cycle W1C, and non-matching read floats
      irq_lines = 8'h01; wr(FA, 8'h01);
      rd(FA, d); chk("edge over clear", 32'(d), 32'h01);
      rd(16'h003B, d); chk("hiz read", 32'((d === 8'hzz) || (d === 8'h00)), 1);
      step();
      chk("edge clear vector", 32'(bif.vector), 1);
      pulse_ack(); pulse_done();
      irq_lines = 0; step();
      // async reset while in service
      irq_lines = 8'h40; step(); step();
      chk("pre reset vector", 32'(bif.vector), 7);
      pulse_ack();
      irq_lines = 8'hC0; step();
      rd(FA, d); chk("pre reset ifr", 32'(d), 32'h80);
      #1 reset = 1;
      #1 model_reset();
      chk("async irq", 32'(bif.irq), 0);
      chk("async vector", 32'(bif.vector), 1);
      rd(FA, d); chk("async ifr", 32'(d), 0);
      rd(MA, d); chk("async imsk", 32'(d), 0);
      irq_lines = 0; step();
      reset = 0;
      pulse_done(); step();
      chk("post reset done irq", 32'(bif.irq), 0);
      rd(FA, d); chk("post reset ifr", 32'(d), 0);
      // random traffic against the model
      for (int n = 0; n < 500; n++) begin
         irq_lines = irq_lines ^ 8'($urandom & $urandom & $urandom);
         bif.global_ie = $urandom_range(0, 7) != 0;
         bif.irq_ack = $urandom_range(0, 2) == 0;
         bif.irq_done = $urandom_range(0, 3) == 0;
         case ($urandom_range(0, 9))
            0: wr(MA, 8'($urandom));
            1: wr(FA, 8'($urandom));
            default: step();
         endcase
         rd(FA, d); chk("rand ifr", 32'(d), 32'(m_pend));
         rd(MA, d); chk("rand imsk", 32'(d), 32'(m_mask));
      end
      bif.irq_ack = 0; bif.irq_done = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
